// File: rtl/mulchan_rd_arbiter_rr.sv
// Multi-channel read arbiter: picks one of NUM_CH requesters (round-robin or fixed
// priority), latches its address/length and holds the grant until the burst completes.
module mulchan_rd_arbiter_rr #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 30,
    parameter int LEN_W   = 8,
    parameter int MODE    = 0,
    parameter int TIMEOUT = 4096,
    parameter int ID_W    = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        rd_req,
    input  logic [NUM_CH-1:0]        chan_en,
    input  logic [NUM_CH*ADDR_W-1:0] rd_addr,
    input  logic [NUM_CH*LEN_W-1:0]  rd_len,
    output logic [NUM_CH-1:0]        rd_grant,
    output logic [ID_W-1:0]          grant_id,
    output logic                     axi_rd_start,
    input  logic                     axi_rd_ready,
    output logic [ADDR_W-1:0]        axi_rd_addr,
    output logic [LEN_W-1:0]         axi_rd_len,
    input  logic                     rd_done,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
    localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state;
    logic [WD_W-1:0]     wd_cnt;
    logic [ID_W-1:0]     last_ptr;

    logic [NUM_CH-1:0]   elig;
    logic [ID_W-1:0]     win;
    logic                found;
    int                  scan_idx;
    logic [ADDR_W-1:0]   win_addr;
    logic [LEN_W-1:0]    win_len;
    logic                wd_expire;

    assign elig      = rd_req & chan_en;
    assign wd_expire = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

    // Round-robin scans upward from the channel after the last winner; fixed
    // priority always scans from channel 0.
    always_comb begin
        win      = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (MODE == 1) begin
                scan_idx = i;
            end else begin
                scan_idx = (int'(last_ptr) + 1 + i) % NUM_CH;
            end
            if (!found && elig[scan_idx]) begin
                found = 1'b1;
                win   = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        win_addr = rd_addr[int'(win)*ADDR_W +: ADDR_W];
        win_len  = rd_len[int'(win)*LEN_W +: LEN_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rd_grant     <= '0;
            grant_id     <= '0;
            axi_rd_start <= 1'b0;
            axi_rd_addr  <= '0;
            axi_rd_len   <= '0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            wd_cnt       <= '0;
            last_ptr     <= ID_W'(NUM_CH - 1);
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state        <= ISSUE;
                        rd_grant     <= ONE_HOT0 << win;
                        grant_id     <= win;
                        axi_rd_addr  <= win_addr;
                        axi_rd_len   <= win_len;
                        axi_rd_start <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (axi_rd_ready) begin
                        axi_rd_start <= 1'b0;
                        wd_cnt       <= '0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    // A real completion in the same cycle as expiry suppresses the error.
                    if (rd_done || wd_expire) begin
                        rd_grant    <= '0;
                        last_ptr    <= grant_id;
                        busy        <= 1'b0;
                        timeout_err <= !rd_done;
                        state       <= IDLE;
                    end else if (TIMEOUT != 0) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    rd_grant     <= '0;
                    axi_rd_start <= 1'b0;
                    busy         <= 1'b0;
                    wd_cnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mulchan_rd_arbiter_rr.sv
// Directed bench: one round-robin and one fixed-priority instance share all inputs,
// so their handshakes run in lockstep while grant choices are checked per instance.
module tb_mulchan_rd_arbiter_rr;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   rd_req;
    logic [3:0]   chan_en;
    logic [119:0] rd_addr;
    logic [31:0]  rd_len;
    logic         ready;
    logic         done;

    logic [3:0]  g0, g1;
    logic [1:0]  id0, id1;
    logic        st0, st1;
    logic [29:0] ad0, ad1;
    logic [7:0]  ln0, ln1;
    logic        by0, by1;
    logic        to0, to1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mulchan_rd_arbiter_rr #(.NUM_CH(4), .ADDR_W(30), .LEN_W(8), .MODE(0), .TIMEOUT(16)) dut_rr (
        .clk(clk), .rst(rst), .rd_req(rd_req), .chan_en(chan_en), .rd_addr(rd_addr),
        .rd_len(rd_len), .rd_grant(g0), .grant_id(id0), .axi_rd_start(st0),
        .axi_rd_ready(ready), .axi_rd_addr(ad0), .axi_rd_len(ln0), .rd_done(done),
        .busy(by0), .timeout_err(to0)
    );

    mulchan_rd_arbiter_rr #(.NUM_CH(4), .ADDR_W(30), .LEN_W(8), .MODE(1), .TIMEOUT(16)) dut_fp (
        .clk(clk), .rst(rst), .rd_req(rd_req), .chan_en(chan_en), .rd_addr(rd_addr),
        .rd_len(rd_len), .rd_grant(g1), .grant_id(id1), .axi_rd_start(st1),
        .axi_rd_ready(ready), .axi_rd_addr(ad1), .axi_rd_len(ln1), .rd_done(done),
        .busy(by1), .timeout_err(to1)
    );

    function automatic logic [29:0] addr_of(input int i);
        return 30'(32'h1000 * (i + 1));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete burst: arbitrate, accept immediately, complete.
    task automatic burst(input int e0, input int e1);
        step();
        chk("rr_start", 64'(st0), 64'd1);
        chk("rr_id", 64'(id0), 64'(e0));
        chk("rr_grant", 64'(g0), 64'(1 << e0));
        chk("rr_addr", 64'(ad0), 64'(addr_of(e0)));
        chk("rr_len", 64'(ln0), 64'(e0 + 1));
        chk("fp_id", 64'(id1), 64'(e1));
        chk("fp_grant", 64'(g1), 64'(1 << e1));
        chk("fp_addr", 64'(ad1), 64'(addr_of(e1)));
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("rr_start_clr", 64'(st0), 64'd0);
        chk("rr_busy_wait", 64'(by0), 64'd1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("rr_grant_clr", 64'(g0), 64'd0);
        chk("rr_busy_idle", 64'(by0), 64'd0);
        chk("fp_grant_clr", 64'(g1), 64'd0);
    endtask

    initial begin
        rst     = 1'b1;
        rd_req  = 4'b0000;
        chan_en = 4'hF;
        ready   = 1'b0;
        done    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_addr[i*30 +: 30] = addr_of(i);
            rd_len[i*8 +: 8]    = 8'(i + 1);
        end
        step();
        step();
        chk("rst_grant", 64'(g0), 64'd0);
        chk("rst_id", 64'(id0), 64'd0);
        chk("rst_start", 64'(st0), 64'd0);
        chk("rst_addr", 64'(ad0), 64'd0);
        chk("rst_len", 64'(ln0), 64'd0);
        chk("rst_busy", 64'(by0), 64'd0);
        chk("rst_to", 64'(to0), 64'd0);
        rst = 1'b0;
        step();
        chk("idle_no_req", 64'(st0), 64'd0);

        // Round-robin order over 1011 is 0,1,3,0; fixed priority always picks 0.
        rd_req = 4'b1011;
        burst(0, 0);
        burst(1, 0);
        burst(3, 0);
        burst(0, 0);

        // 1110: fixed priority keeps channel 1; round-robin continues 1,2,3.
        rd_req = 4'b1110;
        burst(1, 1);
        burst(2, 1);
        burst(3, 1);

        // Ready held low five cycles; request and address change after latch.
        rd_req = 4'b0001;
        step();
        chk("stall_start", 64'(st0), 64'd1);
        chk("stall_id", 64'(id0), 64'd0);
        rd_req = 4'b0000;
        rd_addr[29:0] = 30'h3ABC;
        rd_len[7:0]   = 8'hEE;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_start_hold", 64'(st0), 64'd1);
            chk("stall_addr_hold", 64'(ad0), 64'(addr_of(0)));
            chk("stall_len_hold", 64'(ln0), 64'd1);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("stall_start_drop", 64'(st0), 64'd0);
        chk("stall_grant_lock", 64'(g0), 64'b0001);
        chk("stall_busy", 64'(by0), 64'd1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("stall_done", 64'(by0), 64'd0);
        rd_addr[29:0] = addr_of(0);
        rd_len[7:0]   = 8'd1;

        // Watchdog: no rd_done, expiry 16 cycles after entering WAIT.
        rd_req = 4'b1100;
        step();
        chk("wd_id_rr", 64'(id0), 64'd2);
        chk("wd_id_fp", 64'(id1), 64'd2);
        ready = 1'b1;
        step();
        ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k < 16) begin
                chk("wd_quiet", 64'(to0), 64'd0);
                chk("wd_busy", 64'(by0), 64'd1);
            end else begin
                chk("wd_pulse_rr", 64'(to0), 64'd1);
                chk("wd_pulse_fp", 64'(to1), 64'd1);
                chk("wd_idle", 64'(by0), 64'd0);
                chk("wd_grant_clr", 64'(g0), 64'd0);
            end
        end
        step();
        chk("wd_pulse_end", 64'(to0), 64'd0);
        chk("wd_next_start", 64'(st0), 64'd1);
        chk("wd_next_rr", 64'(id0), 64'd3);
        chk("wd_next_fp", 64'(id1), 64'd2);
        ready = 1'b1;
        step();
        ready = 1'b0;
        done = 1'b1;
        step();
        done = 1'b0;

        // Masked channels 1 and 3 never granted.
        chan_en = 4'b0101;
        rd_req  = 4'b1111;
        burst(0, 0);
        burst(2, 0);
        burst(0, 0);
        burst(2, 0);

        // Reset while waiting on a burst.
        step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("pre_rst_busy", 64'(by0), 64'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_grant", 64'(g0), 64'd0);
        chk("mid_rst_id", 64'(id0), 64'd0);
        chk("mid_rst_start", 64'(st0), 64'd0);
        chk("mid_rst_addr", 64'(ad0), 64'd0);
        chk("mid_rst_len", 64'(ln0), 64'd0);
        chk("mid_rst_busy", 64'(by0), 64'd0);
        chk("mid_rst_fp_grant", 64'(g1), 64'd0);
        chk("mid_rst_fp_busy", 64'(by1), 64'd0);
        rst = 1'b0;
        chan_en = 4'hF;
        step();
        chk("post_rst_start", 64'(st0), 64'd1);
        chk("post_rst_grant", 64'(g0), 64'b0001);
        chk("post_rst_id", 64'(id0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
